// File: rtl/rv64_pkg.sv
// rv64_pkg: shared datapath width, load funct3 encodings and the writeback FIFO entry
package rv64_pkg;
    localparam int XLEN = 64;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic            kill;
    } wb_entry_t;
endpackage

// File: rtl/rv64_load_ext.sv
// rv64_load_ext: selects the addressed byte/half/word of a loaded doubleword and sign/zero-extends it
module rv64_load_ext
    import rv64_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [2:0]      i_addr,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_ext_data
);
    logic [7:0]  w_b;
    logic [15:0] w_h;
    logic [31:0] w_w;
    assign w_b = i_data[{i_addr, 3'b000} +: 8];
    assign w_h = i_data[{i_addr[2:1], 4'b0000} +: 16];
    assign w_w = i_data[{i_addr[2], 5'b00000} +: 32];
    always_comb begin
        o_ext_data = i_funct3 == F3_LB  ? {{(XLEN-8){w_b[7]}}, w_b}
                   : i_funct3 == F3_LH  ? {{(XLEN-16){w_h[15]}}, w_h}
                   : i_funct3 == F3_LW  ? {{(XLEN-32){w_w[31]}}, w_w}
                   : i_funct3 == F3_LBU ? {{(XLEN-8){1'b0}}, w_b}
                   : i_funct3 == F3_LHU ? {{(XLEN-16){1'b0}}, w_h}
                   : i_funct3 == F3_LWU ? {{(XLEN-32){1'b0}}, w_w}
                   : i_data;
    end
endmodule

// File: rtl/rv64_writeback_unit.sv
// rv64_writeback_unit: merges ALU and LSU results onto the regfile write port; RV64_WB_PENDING_EN enables the pending_o scoreboard
module rv64_writeback_unit
    import rv64_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int REGNUM     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid_i,
    input  logic [4:0]        alu_rd_i,
    input  logic [XLEN-1:0]   alu_data_i,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [4:0]        lsu_rd_i,
    input  logic [2:0]        lsu_funct3_i,
    input  logic [2:0]        lsu_addr_i,
    input  logic [XLEN-1:0]   lsu_data_i,
    output logic              we_o,
    output logic [4:0]        waddr_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [REGNUM-1:0] pending_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    wb_entry_t       r_fifo [FIFO_DEPTH];
    logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            r_we;
    logic [4:0]      r_waddr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] w_ext;
    wb_entry_t       w_head;
    logic            w_empty, w_alu, w_lsu_live, w_pop, w_head_out, w_bypass, w_push;
    rv64_load_ext u_ext (
        .i_funct3   (lsu_funct3_i),
        .i_addr     (lsu_addr_i),
        .i_data     (lsu_data_i),
        .o_ext_data (w_ext)
    );
    assign lsu_ready_o = r_count != CW'(FIFO_DEPTH);
    assign w_empty     = r_count == '0;
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_alu       = alu_valid_i && alu_rd_i != 5'd0;
    // a same-cycle ALU write to the same rd is younger, so the load is simply dropped
    assign w_lsu_live  = lsu_valid_i && lsu_ready_o && lsu_rd_i != 5'd0 && !(w_alu && alu_rd_i == lsu_rd_i);
    assign w_pop       = !w_empty && (!w_alu || w_head.kill);
    assign w_head_out  = w_pop && !w_alu && !w_head.kill;
    assign w_bypass    = w_lsu_live && w_empty && !w_alu;
    assign w_push      = w_lsu_live && !w_bypass;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_alu || w_head_out || w_bypass;
            if (w_alu) begin
                r_waddr <= alu_rd_i;
                r_wdata <= alu_data_i;
            end else if (w_head_out) begin
                r_waddr <= w_head.rd;
                r_wdata <= w_head.data;
            end else if (w_bypass) begin
                r_waddr <= lsu_rd_i;
                r_wdata <= w_ext;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                if (w_alu && r_fifo[i].rd == alu_rd_i) r_fifo[i].kill <= 1'b1;
            if (w_push) r_fifo[r_wr_ptr] <= '{rd: lsu_rd_i, data: w_ext, kill: 1'b0};
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
`ifdef RV64_WB_PENDING_EN
    always_comb begin
        pending_o = '0;
        if (r_we) pending_o[r_waddr] = 1'b1;
        for (int k = 0; k < FIFO_DEPTH; k++)
            if (CW'(k) < r_count && !r_fifo[r_rd_ptr + AW'(k)].kill)
                pending_o[r_fifo[r_rd_ptr + AW'(k)].rd] = 1'b1;
    end
`else
    assign pending_o = '0;
`endif
    assign we_o    = r_we;
    assign waddr_o = r_waddr;
    assign wdata_o = r_wdata;
endmodule

// File: tb/tb_rv64_writeback_unit.sv
// tb_rv64_writeback_unit: directed vectors checked against a queue-based model plus literal expectations
module tb_rv64_writeback_unit;
    import rv64_pkg::*;
    localparam int DEPTH = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid_i = 1'b0;
    logic [4:0]  alu_rd_i = '0;
    logic [63:0] alu_data_i = '0;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_i = '0;
    logic [2:0]  lsu_funct3_i = '0;
    logic [2:0]  lsu_addr_i = '0;
    logic [63:0] lsu_data_i = '0;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [63:0] wdata_o;
    logic [31:0] pending_o;
    int checks = 0;
    int failures = 0;

    rv64_writeback_unit #(.FIFO_DEPTH(DEPTH), .REGNUM(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i),
        .lsu_funct3_i(lsu_funct3_i), .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .pending_o(pending_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference load extension: access size from funct3[1:0], naturally aligned, sign from !funct3[2]
    function automatic logic [63:0] m_ext(input logic [2:0] f, input logic [2:0] a, input logic [63:0] d);
        int n;
        logic [63:0] mask, v;
        n = 1 << f[1:0];
        if (n == 8) return d;
        v = d >> (8 * ((int'(a) / n) * n));
        mask = (64'd1 << (8 * n)) - 64'd1;
        v = v & mask;
        if (!f[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        bit          kill;
    } m_ent_t;
    m_ent_t      q[$];
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [63:0] m_wdata;
    bit          m_alu, m_live;
    m_ent_t      m_h;
    logic [31:0] ep;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_we = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            m_alu  = alu_valid_i && alu_rd_i != 0;
            m_live = lsu_valid_i && q.size() < DEPTH && lsu_rd_i != 0 && !(m_alu && alu_rd_i == lsu_rd_i);
            m_we = 1'b0;
            if (m_alu) begin
                m_we = 1'b1;
                m_waddr = alu_rd_i;
                m_wdata = alu_data_i;
                if (q.size() > 0 && q[0].kill) void'(q.pop_front());
                foreach (q[i]) if (q[i].rd == alu_rd_i) q[i].kill = 1'b1;
            end else if (q.size() > 0) begin
                m_h = q.pop_front();
                if (!m_h.kill) begin
                    m_we = 1'b1;
                    m_waddr = m_h.rd;
                    m_wdata = m_h.data;
                end
            end else if (m_live) begin
                m_we = 1'b1;
                m_waddr = lsu_rd_i;
                m_wdata = m_ext(lsu_funct3_i, lsu_addr_i, lsu_data_i);
                m_live = 1'b0;
            end
            if (m_live) q.push_back('{lsu_rd_i, m_ext(lsu_funct3_i, lsu_addr_i, lsu_data_i), 1'b0});
        end
    end

    always @(negedge clk) begin
        ep = '0;
`ifdef RV64_WB_PENDING_EN
        if (m_we) ep[m_waddr] = 1'b1;
        foreach (q[i]) if (!q[i].kill) ep[q[i].rd] = 1'b1;
`endif
        check("cmp_we", 64'(we_o), 64'(m_we));
        if (m_we) begin
            check("cmp_waddr", 64'(waddr_o), 64'(m_waddr));
            check("cmp_wdata", wdata_o, m_wdata);
        end
        check("cmp_ready", 64'(lsu_ready_o), 64'(q.size() < DEPTH));
        check("cmp_pending", 64'(pending_o), 64'(ep));
    end

    task automatic drive(input bit av, input logic [4:0] ard, input logic [63:0] ad,
                         input bit lv, input logic [4:0] lrd, input logic [2:0] f3,
                         input logic [2:0] la, input logic [63:0] ld);
        alu_valid_i = av; alu_rd_i = ard; alu_data_i = ad;
        lsu_valid_i = lv; lsu_rd_i = lrd; lsu_funct3_i = f3; lsu_addr_i = la; lsu_data_i = ld;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] a,
                        input logic [63:0] d, input logic [63:0] exp, input string nm);
        drive(0, 0, 0, 1, rd, f3, a, d);
        check({nm, "_we"}, 64'(we_o), 64'd1);
        check({nm, "_data"}, wdata_o, exp);
        idle();
    endtask

    int acc;
    bit r;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_we", 64'(we_o), 64'd0);
        check("rst_waddr", 64'(waddr_o), 64'd0);
        check("rst_wdata", wdata_o, 64'd0);
        check("rst_ready", 64'(lsu_ready_o), 64'd1);
        check("rst_pending", 64'(pending_o), 64'd0);
        rst = 1'b0;
        idle();
        // ALU single-cycle write
        drive(1, 5, 64'hCAFEBABECAFEBABE, 0, 0, 0, 0, 0);
        check("alu_we", 64'(we_o), 64'd1);
        check("alu_waddr", 64'(waddr_o), 64'd5);
        check("alu_wdata", wdata_o, 64'hCAFEBABECAFEBABE);
        idle();
        check("alu_done", 64'(we_o), 64'd0);
        // load extension through the bypass path
        load(9, F3_LB,  3, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, "lb");
        load(9, F3_LBU, 3, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, "lbu");
        load(9, F3_LH,  5, 64'hFEDC_BA98_7654_3210, 64'hFFFF_FFFF_FFFF_BA98, "lh");
        load(9, F3_LHU, 1, 64'hFEDC_BA98_7654_3210, 64'h0000_0000_0000_3210, "lhu");
        load(9, F3_LW,  4, 64'hFEDC_BA98_7654_3210, 64'hFFFF_FFFF_FEDC_BA98, "lw");
        load(9, F3_LWU, 6, 64'hFEDC_BA98_7654_3210, 64'h0000_0000_FEDC_BA98, "lwu");
        load(9, F3_LB,  7, 64'hFEDC_BA98_7654_3210, 64'hFFFF_FFFF_FFFF_FFFE, "lb7");
        load(9, F3_LD,  5, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, "ld");
        load(9, 3'b111, 2, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, "f3_111");
        // ALU holds the port for 5 cycles; loads fill the FIFO
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            r = lsu_ready_o;
            drive(1, 5'(k + 1), 64'(k), 1, 5'(10 + acc), F3_LD, 0, 64'h1111_0000_0000_0000 + 64'(acc));
            if (r) acc++;
        end
        check("fill_acc", 64'(acc), 64'd4);
        check("fill_ready", 64'(lsu_ready_o), 64'd0);
        check("fill_last_alu", 64'(waddr_o), 64'd5);
        for (int k = 0; k < 4; k++) begin
            idle();
            check("drain_we", 64'(we_o), 64'd1);
            check("drain_waddr", 64'(waddr_o), 64'(10 + k));
            check("drain_wdata", wdata_o, 64'h1111_0000_0000_0000 + 64'(k));
        end
        idle();
        check("drain_end", 64'(we_o), 64'd0);
        // WAW kill of a queued load by a younger ALU write
        drive(1, 1, 64'hA, 1, 7, F3_LD, 0, 64'hDEAD);
        check("waw_a_waddr", 64'(waddr_o), 64'd1);
`ifdef RV64_WB_PENDING_EN
        check("waw_a_pend", 64'(pending_o), 64'h82);
`else
        check("waw_a_pend", 64'(pending_o), 64'd0);
`endif
        drive(1, 7, 64'h7777, 0, 0, 0, 0, 0);
        check("waw_b_waddr", 64'(waddr_o), 64'd7);
        check("waw_b_wdata", wdata_o, 64'h7777);
`ifdef RV64_WB_PENDING_EN
        check("waw_b_pend", 64'(pending_o), 64'h80);
`else
        check("waw_b_pend", 64'(pending_o), 64'd0);
`endif
        idle();
        check("waw_c_we", 64'(we_o), 64'd0);
        check("waw_c_pend", 64'(pending_o), 64'd0);
        idle();
        check("waw_d_we", 64'(we_o), 64'd0);
        // x0 destinations are dropped
        drive(1, 0, 64'h5, 1, 0, F3_LD, 0, 64'h6);
        check("x0_we", 64'(we_o), 64'd0);
        check("x0_pend", 64'(pending_o), 64'd0);
        idle();
        check("x0_we2", 64'(we_o), 64'd0);
        // mixed traffic with collisions, kills and concurrent push/pop
        for (int k = 0; k < 16; k++)
            drive(k % 3 != 2, 5'((k * 3) % 8), 64'h0BAD_0000_0000_0000 + 64'(k),
                  k % 4 != 3, 5'((k * 5) % 8), 3'(k % 8), 3'((k * 3) % 8),
                  64'h8091_A2B3_C4D5_E6F7 + 64'(k) * 64'h0101_0101_0101_0101);
        repeat (8) idle();
        // reset with a full FIFO discards everything
        for (int k = 0; k < 4; k++)
            drive(1, 1, 64'h1, 1, 5'(2 + k), F3_LD, 0, 64'h66 + 64'(k));
        check("pre_rst_ready", 64'(lsu_ready_o), 64'd0);
        rst = 1'b1;
        drive(1, 3, 64'h3, 1, 6, F3_LD, 0, 64'h99);
        check("mid_rst_we", 64'(we_o), 64'd0);
        check("mid_rst_waddr", 64'(waddr_o), 64'd0);
        check("mid_rst_wdata", wdata_o, 64'd0);
        check("mid_rst_pend", 64'(pending_o), 64'd0);
        check("mid_rst_ready", 64'(lsu_ready_o), 64'd1);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            idle();
            check("post_rst_we", 64'(we_o), 64'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
